bk_pipe_adder: RTL and testbench

BK_PIPE_ADDER -- requirements
Module: bk_pipe_adder

---
 rtl/bk_adder_pkg.sv | 21 ++
 rtl/bk_prefix_cell.sv | 16 +
 rtl/bk_pipe_adder.sv | 157 +++++++++++++++
 tb/tb_bk_pipe_adder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_adder_pkg.sv
// Shared definitions for the pipelined Brent-Kung adder: prefix level count,
// per-bit propagate/generate bundle and pipeline latency.
package bk_adder_pkg;

    localparam int unsigned LATENCY = 3;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned lvl;
        lvl = 0;
        while ((64'd1 << lvl) < 64'(value)) begin
            lvl++;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// Brent-Kung prefix operator (black cell); grey positions simply ignore pout.
module bk_prefix_cell (
    input  logic p1,
    input  logic g1,
    input  logic p0,
    input  logic g0,
    output logic pout,
    output logic gout
);

    always_comb begin
        pout = p1 & p0;
        gout = g1 | (p1 & g0);
    end

endmodule

// File: rtl/bk_pipe_adder.sv
// Three-stage pipelined Brent-Kung adder with valid/ready handshake.
// Optional signed-overflow output enabled by defining BK_PIPE_ADDER_OVF_EN.
module bk_pipe_adder
    import bk_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef BK_PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned LVL = clog2(WIDTH);

    logic                      adv;
    logic                      s1_valid;
    logic                      s2_valid;
    pg_t  [WIDTH-1:0]          pre_pg;
    pg_t  [WIDTH-1:0]          s1_pg;
    logic                      s1_cin;
    pg_t  [WIDTH-1:0]          s2_grp;
    logic [WIDTH-1:0]          s2_p;
    logic                      s2_cin;
    pg_t  [LVL:0][WIDTH-1:0]   up;
    pg_t  [LVL-1:0][WIDTH-1:0] dn;
    logic [WIDTH-1:0]          carry;
    logic [WIDTH-1:0]          sum_c;
    logic                      dn_p_unused;

    always_comb begin
        adv      = !out_valid || out_ready;
        in_ready = adv;
    end

    always_comb begin
        pre_pg = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pre_pg[i].p = a[i] ^ b[i];
            pre_pg[i].g = a[i] & b[i];
        end
    end

    // cin enters as bit -1 (p=0, g=cin), merged into position 0 ahead of the up-sweep
    bk_prefix_cell u_fold (
        .p1  (s1_pg[0].p),
        .g1  (s1_pg[0].g),
        .p0  (1'b0),
        .g0  (s1_cin),
        .pout(up[0][0].p),
        .gout(up[0][0].g)
    );
    assign up[0][WIDTH-1:1] = s1_pg[WIDTH-1:1];

    for (genvar l = 0; l < LVL; l++) begin : g_up
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i + 1) % (2 << l) == 0) begin : g_node
                bk_prefix_cell u_cell (
                    .p1  (up[l][i].p),
                    .g1  (up[l][i].g),
                    .p0  (up[l][i - (1 << l)].p),
                    .g0  (up[l][i - (1 << l)].g),
                    .pout(up[l+1][i].p),
                    .gout(up[l+1][i].g)
                );
            end else begin : g_pass
                assign up[l+1][i] = up[l][i];
            end
        end
    end

    assign dn[0] = s2_grp;

    // down-sweep level j fills the midpoints left open by up-sweep level LVL-1-j
    for (genvar j = 1; j < LVL; j++) begin : g_dn
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (((i + 1) % (2 << (LVL - 1 - j)) == (1 << (LVL - 1 - j))) &&
                ((i + 1) > (2 << (LVL - 1 - j)))) begin : g_node
                bk_prefix_cell u_cell (
                    .p1  (dn[j-1][i].p),
                    .g1  (dn[j-1][i].g),
                    .p0  (dn[j-1][i - (1 << (LVL - 1 - j))].p),
                    .g0  (dn[j-1][i - (1 << (LVL - 1 - j))].g),
                    .pout(dn[j][i].p),
                    .gout(dn[j][i].g)
                );
            end else begin : g_pass
                assign dn[j][i] = dn[j-1][i];
            end
        end
    end

    always_comb begin
        carry       = '0;
        dn_p_unused = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            carry[i]    = dn[LVL-1][i].g;
            dn_p_unused = dn_p_unused ^ dn[LVL-1][i].p;
        end
    end

    always_comb begin
        sum_c    = '0;
        sum_c[0] = s2_p[0] ^ s2_cin;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            sum_c[i] = s2_p[i] ^ carry[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef BK_PIPE_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (s2_valid) begin
                sum  <= sum_c;
                cout <= carry[WIDTH-1];
`ifdef BK_PIPE_ADDER_OVF_EN
                ovf  <= carry[WIDTH-2] ^ carry[WIDTH-1];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            s1_pg  <= pre_pg;
            s1_cin <= cin;
            s2_grp <= up[LVL];
            s2_cin <= s1_cin;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                s2_p[i] <= s1_pg[i].p;
            end
        end
    end

endmodule

// File: tb/tb_bk_pipe_adder.sv
// Bench for bk_pipe_adder: four widths (4/8/32/64) driven in lockstep from one
// stream, scored against an arithmetic model. Honours BK_PIPE_ADDER_OVF_EN.
module tb_bk_pipe_adder;
    import bk_adder_pkg::*;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        c;
        int unsigned cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic [63:0] a_bus;
    logic [63:0] b_bus;
    logic        lat_chk;

    logic        rdy4, rdy8, rdy32, rdy64;
    logic        ov4, ov8, ov32, ov64;
    logic        co4, co8, co32, co64;
    logic [3:0]  sum4;
    logic [7:0]  sum8;
    logic [31:0] sum32;
    logic [63:0] sum64;
`ifdef BK_PIPE_ADDER_OVF_EN
    logic        of4, of8, of32, of64;
    logic        got_of [4];
`endif

    logic [63:0] got_sum [4];
    logic        got_co  [4];
    int unsigned wlist   [4] = '{4, 8, 32, 64};

    int          n_err = 0;
    int          n_chk = 0;
    int          n_pop = 0;
    int unsigned cyc   = 0;
    beat_t       sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bk_pipe_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
        .a(a_bus[3:0]), .b(b_bus[3:0]), .cin(cin), .out_valid(ov4),
        .out_ready(out_ready), .sum(sum4), .cout(co4)
`ifdef BK_PIPE_ADDER_OVF_EN
        , .ovf(of4)
`endif
    );
    bk_pipe_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .cin(cin), .out_valid(ov8),
        .out_ready(out_ready), .sum(sum8), .cout(co8)
`ifdef BK_PIPE_ADDER_OVF_EN
        , .ovf(of8)
`endif
    );
    bk_pipe_adder #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
        .a(a_bus[31:0]), .b(b_bus[31:0]), .cin(cin), .out_valid(ov32),
        .out_ready(out_ready), .sum(sum32), .cout(co32)
`ifdef BK_PIPE_ADDER_OVF_EN
        , .ovf(of32)
`endif
    );
    bk_pipe_adder #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
        .a(a_bus), .b(b_bus), .cin(cin), .out_valid(ov64),
        .out_ready(out_ready), .sum(sum64), .cout(co64)
`ifdef BK_PIPE_ADDER_OVF_EN
        , .ovf(of64)
`endif
    );

    always_comb begin
        got_sum[0] = 64'(sum4);
        got_sum[1] = 64'(sum8);
        got_sum[2] = 64'(sum32);
        got_sum[3] = sum64;
        got_co[0]  = co4;
        got_co[1]  = co8;
        got_co[2]  = co32;
        got_co[3]  = co64;
`ifdef BK_PIPE_ADDER_OVF_EN
        got_of[0]  = of4;
        got_of[1]  = of8;
        got_of[2]  = of32;
        got_of[3]  = of64;
`endif
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Plain wide arithmetic: bits [w-1:0] are the sum, bit w the carry-out.
    function automatic logic [64:0] ref_add(input int unsigned w, input logic [63:0] av,
                                            input logic [63:0] bv, input logic cv);
        logic [64:0] m;
        m = (65'd1 << w) - 65'd1;
        return ({1'b0, av} & m) + ({1'b0, bv} & m) + 65'(cv);
    endfunction

    task automatic check_beat(input beat_t e);
        logic [64:0] full;
        logic [63:0] mask;
        int unsigned w;
        for (int k = 0; k < 4; k++) begin
            w    = wlist[k];
            full = ref_add(w, e.a, e.b, e.c);
            mask = 64'(((65'd1 << w) - 65'd1));
            check($sformatf("sum_w%0d", w), got_sum[k], full[63:0] & mask);
            check($sformatf("cout_w%0d", w), 64'(got_co[k]), 64'(full[w]));
`ifdef BK_PIPE_ADDER_OVF_EN
            check($sformatf("ovf_w%0d", w), 64'(got_of[k]),
                  64'((e.a[w-1] == e.b[w-1]) && (full[w-1] != e.a[w-1])));
`endif
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            sb_q.delete();
        end else begin
            if (ov32 && out_ready) begin
                n_pop++;
                if (sb_q.size() == 0) begin
                    check("orphan_result", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_beat(e);
                    if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(LATENCY));
                end
            end
            if (in_valid && rdy32) sb_q.push_back('{a_bus, b_bus, cin, cyc});
        end
    end

    task automatic send1(input logic [63:0] av, input logic [63:0] bv, input logic cv,
                         input logic [7:0] es, input logic ec);
        int n;
        lat_chk = 1'b1;
        @(posedge clk); #1;
        a_bus = av; b_bus = bv; cin = cv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!ov8 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("w8_out_valid", 64'(ov8), 64'd1);
        if (ov8) begin
            check("w8_sum", 64'(sum8), 64'(es));
            check("w8_cout", 64'(co8), 64'(ec));
        end
        @(posedge clk); #1;
        lat_chk = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] a1, b1;
        logic        c1, acc;
        logic [64:0] full;
        int          p0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; cin = 1'b0;
        a_bus = '0; b_bus = '0; lat_chk = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(rdy32), 64'd1);
        check("rst_out_valid", 64'(ov32), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_sum_w%0d", wlist[k]), got_sum[k], 64'd0);
            check($sformatf("rst_cout_w%0d", wlist[k]), 64'(got_co[k]), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        send1(64'h7F, 64'h01, 1'b0, 8'h80, 1'b0);
        send1(64'hFF, 64'hFF, 1'b1, 8'hFF, 1'b1);
        send1(64'hFF, 64'h00, 1'b1, 8'h00, 1'b1);
        send1('1, '1, 1'b1, 8'hFF, 1'b1);

        // back-to-back stream
        p0 = n_pop;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            @(negedge clk);
            check("stream_in_ready", 64'(rdy32), 64'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("stream_count", 64'(n_pop - p0), 64'd100);

        // stall with three beats in flight and a fourth held upstream
        p0 = n_pop;
        @(posedge clk); #1;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; c1 = 1'($urandom_range(0, 1));
        a_bus = a1; b_bus = b1; cin = c1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom};
            cin = 1'($urandom_range(0, 1));
            if (i == 2) out_ready = 1'b0;
        end
        full = ref_add(32, a1, b1, c1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(rdy32), 64'd0);
            check("stall_out_valid", 64'(ov32), 64'd1);
            check("stall_sum_w32", 64'(sum32), 64'(full[31:0]));
            check("stall_cout_w32", 64'(co32), 64'(full[32]));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("stall_drain_count", 64'(n_pop - p0), 64'd4);
        check("stall_queue_empty", 64'(sb_q.size()), 64'd0);

        // reset with two beats in flight, a third offered during reset
        p0 = n_pop;
        @(posedge clk); #1;
        a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom}; in_valid = 1'b1;
        @(posedge clk); #1;
        a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom};
        @(posedge clk); #1;
        a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom}; rst = 1'b1;
        @(negedge clk);
        check("rst_mid_in_ready", 64'(rdy32), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("rst_mid_out_valid", 64'(ov32), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rst_mid_sum_w%0d", wlist[k]), got_sum[k], 64'd0);
            check($sformatf("rst_mid_cout_w%0d", wlist[k]), 64'(got_co[k]), 64'd0);
        end
        repeat (8) @(negedge clk);
        check("rst_mid_no_output", 64'(n_pop - p0), 64'd0);

        // random valid/ready toggling; upstream holds an unaccepted beat
        p0 = n_pop;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            acc = in_valid && rdy32;
            @(posedge clk); #1;
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a_bus = {$urandom, $urandom}; b_bus = {$urandom, $urandom};
                cin = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("random_results_seen", 64'(n_pop > p0 + 1000), 64'd1);
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
